dsram_confreg: RTL and testbench
================================

DSRAM_CONFREG -- requirements
Module: dsram_confreg

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, RAM word-address width (2^RAM_AW words).
REQ-002 The block SHALL have parameter SIMU, default 1, value returned by the SIMU_FLAG register (bit 0).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; resetn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port data_sram_en  input  1  access request this cycle.
REQ-005 The block SHALL have port data_sram_we  input  4  byte write enables; 0 means read.
REQ-006 The block SHALL have port data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 The block SHALL have port data_sram_wdata  input  32  write data.
REQ-008 The block SHALL have port data_sram_rdata  output  32  read data.
REQ-009 The block SHALL have port switch_i  input  8  asynchronous board switches.
REQ-010 The block SHALL have ports led_o  output  16  LED register, and num_o  output  32  display register.

Function
REQ-011 Address decode SHALL be: addr[31:16]==16'hBFAF selects confreg; any other address selects RAM at word index addr[RAM_AW+1:2], aliased modulo depth.
REQ-012 Confreg map SHALL be: 0xBFAF_E000 TIMER (rw); 0xBFAF_F020 LED (rw, bits [15:0]); 0xBFAF_F030 SWITCH (ro, zero-extended); 0xBFAF_F050 NUM (rw); 0xBFAF_FFF0 SIMU_FLAG (ro, {31'b0, SIMU}).
REQ-013 Reads SHALL have fixed 1-cycle latency: for en=1 and we=0 in cycle N, rdata is valid in cycle N+1.
REQ-014 rdata SHALL hold its last value in cycles following an idle cycle (en=0) or a write.
REQ-015 RAM writes SHALL update only the bytes whose we bit is set.
REQ-016 Confreg writes SHALL take effect only when we==4'hF; partial writes to confreg, and any write to SWITCH, SIMU_FLAG or an unmapped confreg address, SHALL be dropped.
REQ-017 Reads of unmapped confreg addresses SHALL return 32'h0.
REQ-018 TIMER SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-019 A TIMER write in cycle N SHALL make TIMER equal to wdata in cycle N+1, and that write SHALL take priority over the increment.
REQ-020 A TIMER read SHALL return the counter value sampled on the request edge.
REQ-021 switch_i SHALL pass through a 2-flop synchronizer before it becomes readable, giving at most 3 cycles from pin change to rdata.
REQ-022 Access to SWITCH is read-only, so no simultaneous read and write to one address occurs on it; for RAM and for the rw confreg registers, a same-address read-after-write in the next cycle SHALL return the newly written data.
REQ-023 When en=0, we SHALL be ignored and no state other than TIMER and the synchronizer SHALL change.

Reset
REQ-024 While resetn=0, the block SHALL force rdata=0, led_o=16'h0000, num_o=0, TIMER=0 and synchronizer flops=0.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 An access presented in the cycle resetn deasserts SHALL be serviced normally.

Structure
REQ-027 The confreg offsets, the 16'hBFAF window tag and the SIMU_FLAG offset SHALL be defined in a shared package dsram_pkg.
REQ-028 RAM storage with byte-enable write and registered read SHALL be a sub-module dsram_bram with parameter RAM_AW.
REQ-029 The top SHALL contain only decode, the confreg registers, TIMER, the synchronizer and the rdata mux.

Verification
REQ-030 Write 0x1C00_0010, we=F, data 0xDEADBEEF, then write we=4'b0010 with data 0x0000_5500, then read -> rdata=0xDEAD55EF one cycle after the read request.
REQ-031 Write 0x1C00_1010 (aliases word 4 when RAM_AW=10) with 0x12345678, then read 0x1C00_0010 -> 0x12345678.
REQ-032 Write TIMER=0xFFFF_FFFE, idle 3 cycles, read TIMER -> 0x0000_0001 (wrap verified).
REQ-033 Write LED with we=4'b0011 -> led_o unchanged; write with we=F and data 0x0001_A5A5 -> led_o=16'hA5A5 next cycle; read LED -> 0x0000_A5A5.
REQ-034 Set switch_i=8'h3C, wait 3 cycles, read 0xBFAF_F030 -> 0x0000_003C; read 0xBFAF_FFF0 -> 0x1; read 0xBFAF_F040 -> 0.
REQ-035 Assert resetn=0 mid-stream after NUM=0x55 -> num_o=0 and rdata=0 immediately; RAM word written before reset reads back unchanged after release.

Source files
------------

// File: rtl/dsram_pkg.sv
// Shared address map for the data-SRAM / config-register block: window tag,
// register offsets and the offset-to-register decoder.
package dsram_pkg;

  localparam logic [15:0] CONF_TAG      = 16'hBFAF;
  localparam logic [15:0] OFF_TIMER     = 16'hE000;
  localparam logic [15:0] OFF_LED       = 16'hF020;
  localparam logic [15:0] OFF_SWITCH    = 16'hF030;
  localparam logic [15:0] OFF_NUM       = 16'hF050;
  localparam logic [15:0] OFF_SIMU_FLAG = 16'hFFF0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TIMER,
    REG_LED,
    REG_SWITCH,
    REG_NUM,
    REG_SIMU
  } conf_reg_e;

  // Decodes a word offset (byte offset bits [15:2]) inside the confreg window.
  function automatic conf_reg_e decode_reg(input logic [13:0] word_off);
    case (word_off)
      OFF_TIMER[15:2]:     return REG_TIMER;
      OFF_LED[15:2]:       return REG_LED;
      OFF_SWITCH[15:2]:    return REG_SWITCH;
      OFF_NUM[15:2]:       return REG_NUM;
      OFF_SIMU_FLAG[15:2]: return REG_SIMU;
      default:             return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dsram_bram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Storage and read register are not reset.
module dsram_bram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];

  // The read register only loads on a read, so it holds across idles and writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dsram_confreg.sv
// Data-SRAM port front end: decodes the 0xBFAF window into config registers
// (timer, LEDs, switches, display number, sim flag) and sends the rest to RAM.
module dsram_confreg
  import dsram_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int SIMU   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_i,
  output logic [15:0] led_o,
  output logic [31:0] num_o
);

  // Request protocol: data_sram_en qualifies a single-cycle request with no
  // backpressure; we==0 is a read answered in the next cycle, otherwise a write.
  localparam logic SIMU_BIT = SIMU[0];

  logic        is_conf;
  conf_reg_e   reg_sel;
  logic        rd_req;
  logic        conf_wr;
  logic [31:0] timer;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] conf_rd_val;
  logic [31:0] conf_q;
  logic        rd_from_ram;
  logic [31:0] ram_q;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^data_sram_addr[1:0];

  assign is_conf = (data_sram_addr[31:16] == CONF_TAG);
  assign reg_sel = decode_reg(data_sram_addr[15:2]);
  assign rd_req  = data_sram_en && (data_sram_we == 4'h0);
  assign conf_wr = data_sram_en && is_conf && (data_sram_we == 4'hF);

  dsram_bram #(.RAM_AW(RAM_AW)) u_bram (
    .clk   (clk),
    .en    (data_sram_en && !is_conf),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_q)
  );

  // A software write to TIMER wins over the free-running increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= 32'h0;
    end else if (conf_wr && reg_sel == REG_TIMER) begin
      timer <= data_sram_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_o <= 16'h0;
      num_o <= 32'h0;
    end else if (conf_wr) begin
      if (reg_sel == REG_LED) led_o <= data_sram_wdata[15:0];
      if (reg_sel == REG_NUM) num_o <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= 8'h0;
      sw_sync <= 8'h0;
    end else begin
      sw_meta <= switch_i;
      sw_sync <= sw_meta;
    end
  end

  always_comb begin
    conf_rd_val = 32'h0;
    case (reg_sel)
      REG_TIMER:  conf_rd_val = timer;
      REG_LED:    conf_rd_val = {16'h0, led_o};
      REG_SWITCH: conf_rd_val = {24'h0, sw_sync};
      REG_NUM:    conf_rd_val = num_o;
      REG_SIMU:   conf_rd_val = {31'h0, SIMU_BIT};
      default:    conf_rd_val = 32'h0;
    endcase
  end

  // Source select and confreg read value only move on a read, giving rdata hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_from_ram <= 1'b0;
      conf_q      <= 32'h0;
    end else if (rd_req) begin
      rd_from_ram <= !is_conf;
      if (is_conf) conf_q <= conf_rd_val;
    end
  end

  assign data_sram_rdata = rd_from_ram ? ram_q : conf_q;

endmodule

// File: tb/tb_dsram_confreg.sv
// Self-checking bench for dsram_confreg: directed scenarios plus a randomized
// mix of RAM/confreg traffic checked against an address-map level model.
module tb_dsram_confreg;

  localparam int RAM_AW = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_i = 8'h0;
  logic [15:0] led_o;
  logic [31:0] num_o;

  dsram_confreg #(.RAM_AW(RAM_AW), .SIMU(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_i        (switch_i),
    .led_o           (led_o),
    .num_o           (num_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [15:0] m_led = 16'h0;
  logic [31:0] m_num = 32'h0;
  logic [7:0]  m_sw = 8'h0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_timer_base = 32'h0;
  int unsigned m_timer_cycle = 0;
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] model_timer();
    return m_timer_base + 32'(cyc_n - m_timer_cycle);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    if (a[31:16] == 16'hBFAF) begin
      off = {16'h0, a[15:2], 2'b00};
      case (off)
        32'hE000: return model_timer();
        32'hF020: return {16'h0, m_led};
        32'hF030: return {24'h0, m_sw};
        32'hF050: return m_num;
        32'hFFF0: return 32'h1;
        default:  return 32'h0;
      endcase
    end
    return m_mem.exists(int'(a[RAM_AW+1:2])) ? m_mem[int'(a[RAM_AW+1:2])] : 32'hx;
  endfunction

  task automatic model_write(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word;
    int idx;
    if (a[31:16] == 16'hBFAF) begin
      if (w == 4'hF) begin
        case ({a[15:2], 2'b00})
          16'hE000: begin m_timer_base = d; m_timer_cycle = cyc_n + 1; end
          16'hF020: m_led = d[15:0];
          16'hF050: m_num = d;
          default: ;
        endcase
      end
    end else begin
      idx = int'(a[RAM_AW+1:2]);
      word = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
      m_mem[idx] = word;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_outputs();
    if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
    check_eq("rdata", data_sram_rdata, m_rdata);
    check_eq("led_o", {16'h0, led_o}, {16'h0, m_led});
    check_eq("num_o", num_o, m_num);
  endtask

  task automatic drive_op(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    data_sram_en = e;
    data_sram_we = w;
    data_sram_addr = a;
    data_sram_wdata = d;
    if (e) begin
      if (w == 4'h0) exp_q.push_back(model_read(a));
      else model_write(w, a, d);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check_outputs();
    drive_op(e, w, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    step(1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 4'h0, a, $urandom);
  endtask

  // Idle cycles carry random we/addr/wdata that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    check_outputs();
    resetn = 1'b0;
    data_sram_en = 1'b0;
    m_led = 16'h0;
    m_num = 32'h0;
    m_rdata = 32'h0;
    exp_q.delete();
    #1;
    check_eq("rst_rdata", data_sram_rdata, 32'h0);
    check_eq("rst_num", num_o, 32'h0);
    check_eq("rst_led", {16'h0, led_o}, 32'h0);
  endtask

  // Releases reset at a negedge and presents a read in that same cycle.
  task automatic release_with_read(input logic [31:0] a);
    @(negedge clk);
    check_outputs();
    resetn = 1'b1;
    m_timer_base = 32'h0;
    m_timer_cycle = cyc_n;
    drive_op(1'b1, 4'h0, a, 32'h0);
  endtask

  function automatic logic [31:0] ram_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[RAM_AW+1:2] = RAM_AW'(idx);
    if (a[31:16] == 16'hBFAF) a[31:16] = 16'h1C00;
    return a;
  endfunction

  function automatic logic [31:0] conf_addr();
    logic [15:0] offs [7];
    offs = '{16'hE000, 16'hF020, 16'hF030, 16'hF050, 16'hFFF0, 16'hF040, 16'h0000};
    return {16'hBFAF, offs[$urandom_range(0, 6)] | 16'($urandom_range(0, 3))};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    release_with_read(32'hBFAF_E000);
    idle(1);

    // Byte-enable merge
    wr(32'h1C00_0010, 4'hF, 32'hDEAD_BEEF);
    wr(32'h1C00_0010, 4'b0010, 32'h0000_5500);
    rd(32'h1C00_0010);
    idle(1);
    check_eq("byte_merge", data_sram_rdata, 32'hDEAD_55EF);

    // Aliasing modulo depth
    wr(32'h1C00_1010, 4'hF, 32'h1234_5678);
    rd(32'h1C00_0010);
    idle(1);
    check_eq("alias", data_sram_rdata, 32'h1234_5678);

    // Timer wrap
    wr(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFE);
    idle(3);
    rd(32'hBFAF_E000);
    idle(1);
    check_eq("timer_wrap", data_sram_rdata, 32'h0000_0001);

    // LED partial write dropped, full write taken
    wr(32'hBFAF_F020, 4'b0011, 32'h0000_1234);
    idle(1);
    check_eq("led_partial", {16'h0, led_o}, 32'h0);
    wr(32'hBFAF_F020, 4'hF, 32'h0001_A5A5);
    rd(32'hBFAF_F020);
    check_eq("led_full", {16'h0, led_o}, 32'h0000_A5A5);
    idle(1);
    check_eq("led_read", data_sram_rdata, 32'h0000_A5A5);

    // Switch synchronizer, sim flag, unmapped
    switch_i = 8'h3C;
    m_sw = 8'h3C;
    idle(3);
    rd(32'hBFAF_F030);
    rd(32'hBFAF_FFF0);
    check_eq("switch", data_sram_rdata, 32'h0000_003C);
    rd(32'hBFAF_F040);
    check_eq("simu_flag", data_sram_rdata, 32'h1);
    idle(1);
    check_eq("unmapped", data_sram_rdata, 32'h0);

    // Fill a small working set of RAM words
    for (int i = 0; i < 16; i++) wr(ram_addr(i), 4'hF, $urandom);

    // Randomized mix
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: wr(ram_addr($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom);
        3, 4:    rd(ram_addr($urandom_range(0, 15)));
        5:       wr(conf_addr(), ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 14)), $urandom);
        6, 7:    rd(conf_addr());
        8:       idle(1);
        default: begin
          idle(1);
          switch_i = 8'($urandom);
          m_sw = switch_i;
          idle(2);
        end
      endcase
    end

    // Mid-stream reset: registers cleared, RAM kept
    wr(ram_addr(3), 4'hF, 32'hA5A5_0003);
    wr(32'hBFAF_F050, 4'hF, 32'h0000_0055);
    rd(ram_addr(3));
    idle(1);
    check_eq("num_set", num_o, 32'h0000_0055);
    check_eq("pre_rst_rd", data_sram_rdata, 32'hA5A5_0003);
    assert_reset();
    idle(2);
    release_with_read(ram_addr(3));
    idle(1);
    check_eq("ram_kept", data_sram_rdata, 32'hA5A5_0003);
    rd(32'hBFAF_E000);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
